// File: rtl/i2c_slave_reg_rx.sv
// rtl/i2c_slave_reg_rx.sv - write-only I2C slave that turns addressed data bytes into register write strobes
// Optional majority glitch filter on SCL/SDA: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_reg_rx #(
   parameter logic [6:0] DEV_ADDR = 7'h0A,
   parameter int         NUM_REGS = 30,
   parameter int         ADDR_W   = 8
) (
   input  logic              clk_sda,
   input  logic              rst_n,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic              reg_wr_en,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              busy,
   output logic              nack_err
);

   typedef enum logic [2:0] {
      IDLE,
      DEV,
      DEV_ACK,
      REG,
      REG_ACK,
      DATA,
      DATA_ACK,
      IGNORE
   } state_t;

   localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};

   logic [1:0] scl_sync;
   logic [1:0] sda_sync;
   logic       scl_v;
   logic       sda_v;
   logic       scl_q;
   logic       sda_q;

   // Synchronizers idle high so reset release never looks like a bus event.
   always_ff @(posedge clk_sda or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], scl_in};
         sda_sync <= {sda_sync[0], sda_in};
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [1:0] scl_hist;
   logic [1:0] sda_hist;
   logic       scl_filt;
   logic       sda_filt;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // A level must be seen on two of three consecutive samples before it propagates.
   always_ff @(posedge clk_sda or negedge rst_n) begin
      if (!rst_n) begin
         scl_hist <= 2'b11;
         sda_hist <= 2'b11;
         scl_filt <= 1'b1;
         sda_filt <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[0], scl_sync[1]};
         sda_hist <= {sda_hist[0], sda_sync[1]};
         scl_filt <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
         sda_filt <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
      end
   end

   assign scl_v = scl_filt;
   assign sda_v = sda_filt;
`else
   assign scl_v = scl_sync[1];
   assign sda_v = sda_sync[1];
`endif

   always_ff @(posedge clk_sda or negedge rst_n) begin
      if (!rst_n) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_v;
         sda_q <= sda_v;
      end
   end

   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   assign scl_rise  = scl_v & ~scl_q;
   assign scl_fall  = ~scl_v & scl_q;
   assign start_det = scl_v & scl_q & sda_q & ~sda_v;
   assign stop_det  = scl_v & scl_q & ~sda_q & sda_v;

   state_t            state, state_n;
   logic [2:0]        bit_cnt, bit_cnt_n;
   logic [6:0]        shreg, shreg_n;
   logic [ADDR_W-1:0] ptr, ptr_n;
   logic              ack_phase, ack_phase_n;
   logic              sda_oe_n;
   logic              busy_n;
   logic              wr_en_n;
   logic              nack_n;
   logic [ADDR_W-1:0] addr_n;
   logic [7:0]        wdata_n;
   logic [7:0]        byte_next;
   logic              shifting;
   logic              byte_done;

   assign byte_next = {shreg, sda_v};
   assign shifting  = (state == DEV) || (state == REG) || (state == DATA);
   assign byte_done = shifting && scl_rise && (bit_cnt == 3'd0);

   always_ff @(posedge clk_sda or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= 3'd7;
         shreg     <= '0;
         ptr       <= '0;
         ack_phase <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         reg_wr_en <= 1'b0;
         nack_err  <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         ptr       <= ptr_n;
         ack_phase <= ack_phase_n;
         sda_oe    <= sda_oe_n;
         busy      <= busy_n;
         reg_wr_en <= wr_en_n;
         nack_err  <= nack_n;
         reg_addr  <= addr_n;
         reg_wdata <= wdata_n;
      end
   end

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shreg_n     = shreg;
      ptr_n       = ptr;
      ack_phase_n = ack_phase;
      sda_oe_n    = sda_oe;
      busy_n      = busy;
      wr_en_n     = 1'b0;
      nack_n      = 1'b0;
      addr_n      = reg_addr;
      wdata_n     = reg_wdata;

      if (stop_det) begin
         state_n     = IDLE;
         bit_cnt_n   = 3'd7;
         ack_phase_n = 1'b0;
         sda_oe_n    = 1'b0;
         busy_n      = 1'b0;
      end else if (start_det) begin
         state_n     = DEV;
         bit_cnt_n   = 3'd7;
         ack_phase_n = 1'b0;
         sda_oe_n    = 1'b0;
         busy_n      = 1'b1;
      end else begin
         // The counter wraps 0 -> 7 so it is ready for the next byte after the ACK clock.
         if (shifting && scl_rise) begin
            shreg_n   = byte_next[6:0];
            bit_cnt_n = bit_cnt - 3'd1;
         end

         case (state)
            DEV: begin
               if (byte_done) begin
                  if (byte_next[7:1] != DEV_ADDR) begin
                     state_n = IGNORE;
                  end else if (byte_next[0]) begin
                     nack_n  = 1'b1;
                     state_n = IGNORE;
                  end else begin
                     state_n = DEV_ACK;
                  end
               end
            end
            REG: begin
               if (byte_done) begin
                  ptr_n   = ADDR_W'(byte_next);
                  state_n = REG_ACK;
               end
            end
            DATA: begin
               if (byte_done) begin
                  if ({1'b0, ptr} < REG_LIMIT) begin
                     wr_en_n = 1'b1;
                     addr_n  = ptr;
                     wdata_n = byte_next;
                     ptr_n   = (ptr == PTR_MAX) ? ptr : ptr + 1'b1;
                     state_n = DATA_ACK;
                  end else begin
                     nack_n  = 1'b1;
                     state_n = IGNORE;
                  end
               end
            end
            // First SCL fall after bit 0 starts the ACK drive, the next one ends it.
            DEV_ACK, REG_ACK, DATA_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_oe_n    = 1'b1;
                     ack_phase_n = 1'b1;
                  end else begin
                     sda_oe_n    = 1'b0;
                     ack_phase_n = 1'b0;
                     state_n     = (state == DEV_ACK) ? REG : DATA;
                  end
               end
            end
            default: begin
               state_n = state;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave_reg_rx.sv
// tb/tb_i2c_slave_reg_rx.sv - directed bench driving I2C master waveforms with a write scoreboard
module tb_i2c_slave_reg_rx;

   localparam int Q = 100;

   logic       clk_sda = 1'b0;
   logic       rst_n   = 1'b0;
   logic       m_scl   = 1'b1;
   logic       m_sda   = 1'b1;
   logic       sda_bus;
   logic       sda_oe;
   logic       reg_wr_en;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       busy;
   logic       nack_err;

   assign sda_bus = m_sda & ~sda_oe;

   always #5 clk_sda = ~clk_sda;

   i2c_slave_reg_rx #(
      .DEV_ADDR(7'h0A),
      .NUM_REGS(30),
      .ADDR_W  (8)
   ) dut (
      .clk_sda  (clk_sda),
      .rst_n    (rst_n),
      .scl_in   (m_scl),
      .sda_in   (sda_bus),
      .sda_oe   (sda_oe),
      .reg_wr_en(reg_wr_en),
      .reg_addr (reg_addr),
      .reg_wdata(reg_wdata),
      .busy     (busy),
      .nack_err (nack_err)
   );

   int          n_pass = 0;
   int          n_total = 0;
   int          n_fail = 0;
   int          wr_count = 0;
   int          nack_count = 0;
   int          oe_count = 0;
   logic        oe_prev = 1'b0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_e;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every strobe must match the oldest pending expected write.
   always @(negedge clk_sda) begin
      if (reg_wr_en) begin
         wr_count++;
         check("wr_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            check("wr_addr", 32'(reg_addr), 32'(exp_e[15:8]));
            check("wr_data", 32'(reg_wdata), 32'(exp_e[7:0]));
         end
      end
      if (nack_err) nack_count++;
      if (sda_oe && !oe_prev) oe_count++;
      oe_prev = sda_oe;
   end

   task automatic i2c_start();
      m_sda = 1'b1;
      #(Q);
      m_scl = 1'b1;
      #(Q);
      m_sda = 1'b0;
      #(Q);
      m_scl = 1'b0;
      #(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      #(Q);
      m_scl = 1'b1;
      #(Q);
      m_sda = 1'b1;
      #(2*Q);
   endtask

   task automatic send_bit(input logic b);
      m_sda = b;
      #(Q);
      m_scl = 1'b1;
      #(2*Q);
      m_scl = 1'b0;
      #(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      m_sda = 1'b1;
      #(Q);
      m_scl = 1'b1;
      #(Q);
      ack = ~sda_bus;
      #(Q);
      m_scl = 1'b0;
      #(Q);
   endtask

   initial begin
      logic       ack;
      logic [7:0] part;
      int         wr0;
      int         nk0;
      int         oe0;

      repeat (5) @(posedge clk_sda);
      @(negedge clk_sda);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_wr_en", 32'(reg_wr_en), 32'd0);
      check("rst_addr", 32'(reg_addr), 32'd0);
      check("rst_wdata", 32'(reg_wdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_nack", 32'(nack_err), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_sda);

      // Nominal burst
      wr0 = wr_count;
      nk0 = nack_count;
      for (int i = 0; i < 11; i++) exp_q.push_back({8'(18 + i), 8'hFF});
      i2c_start();
      check("t1_busy_start", 32'(busy), 32'd1);
      send_byte(8'h14, ack);
      check("t1_dev_ack", 32'(ack), 32'd1);
      send_byte(8'd18, ack);
      check("t1_reg_ack", 32'(ack), 32'd1);
      for (int i = 0; i < 11; i++) begin
         send_byte(8'hFF, ack);
         check("t1_data_ack", 32'(ack), 32'd1);
      end
      i2c_stop();
      repeat (10) @(negedge clk_sda);
      check("t1_busy_stop", 32'(busy), 32'd0);
      check("t1_wr_count", 32'(wr_count - wr0), 32'd11);
      check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t1_nack_count", 32'(nack_count - nk0), 32'd0);

      // Wrong device
      wr0 = wr_count;
      nk0 = nack_count;
      oe0 = oe_count;
      i2c_start();
      send_byte(8'h16, ack);
      check("t2_dev_nack", 32'(ack), 32'd0);
      send_byte(8'd18, ack);
      check("t2_reg_nack", 32'(ack), 32'd0);
      for (int i = 0; i < 2; i++) begin
         send_byte(8'h5A, ack);
         check("t2_data_nack", 32'(ack), 32'd0);
      end
      i2c_stop();
      repeat (10) @(negedge clk_sda);
      check("t2_oe_count", 32'(oe_count - oe0), 32'd0);
      check("t2_nack_count", 32'(nack_count - nk0), 32'd0);
      check("t2_wr_count", 32'(wr_count - wr0), 32'd0);

      // Read request
      wr0 = wr_count;
      nk0 = nack_count;
      i2c_start();
      send_byte(8'h15, ack);
      check("t3_dev_nack", 32'(ack), 32'd0);
      check("t3_nack_pulse", 32'(nack_count - nk0), 32'd1);
      send_byte(8'h42, ack);
      check("t3_ignored_nack", 32'(ack), 32'd0);
      i2c_stop();
      repeat (10) @(negedge clk_sda);
      check("t3_wr_count", 32'(wr_count - wr0), 32'd0);
      check("t3_nack_total", 32'(nack_count - nk0), 32'd1);

      // Range end
      wr0 = wr_count;
      nk0 = nack_count;
      exp_q.push_back({8'd28, 8'h11});
      exp_q.push_back({8'd29, 8'h22});
      i2c_start();
      send_byte(8'h14, ack);
      check("t4_dev_ack", 32'(ack), 32'd1);
      send_byte(8'd28, ack);
      check("t4_reg_ack", 32'(ack), 32'd1);
      send_byte(8'h11, ack);
      check("t4_b0_ack", 32'(ack), 32'd1);
      send_byte(8'h22, ack);
      check("t4_b1_ack", 32'(ack), 32'd1);
      send_byte(8'h33, ack);
      check("t4_b2_nack", 32'(ack), 32'd0);
      check("t4_nack_pulse", 32'(nack_count - nk0), 32'd1);
      i2c_stop();
      repeat (10) @(negedge clk_sda);
      check("t4_wr_count", 32'(wr_count - wr0), 32'd2);
      check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

      // Repeated START in the middle of a data byte
      wr0 = wr_count;
      exp_q.push_back({8'd5, 8'hA5});
      i2c_start();
      send_byte(8'h14, ack);
      check("t5_dev_ack", 32'(ack), 32'd1);
      send_byte(8'd10, ack);
      check("t5_reg_ack", 32'(ack), 32'd1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      i2c_start();
      check("t5_busy_rstart", 32'(busy), 32'd1);
      send_byte(8'h14, ack);
      check("t5_dev2_ack", 32'(ack), 32'd1);
      send_byte(8'd5, ack);
      check("t5_reg2_ack", 32'(ack), 32'd1);
      send_byte(8'hA5, ack);
      check("t5_data_ack", 32'(ack), 32'd1);
      i2c_stop();
      repeat (10) @(negedge clk_sda);
      check("t5_wr_count", 32'(wr_count - wr0), 32'd1);
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset while the slave is driving an ACK in DATA
      wr0 = wr_count;
      exp_q.push_back({8'd3, 8'h5A});
      i2c_start();
      send_byte(8'h14, ack);
      check("t6_dev_ack", 32'(ack), 32'd1);
      send_byte(8'd3, ack);
      check("t6_reg_ack", 32'(ack), 32'd1);
      part = 8'h5A;
      for (int i = 7; i >= 0; i--) send_bit(part[i]);
      m_sda = 1'b1;
      for (int i = 0; i < 200 && !sda_oe; i++) @(negedge clk_sda);
      check("t6_oe_before_rst", 32'(sda_oe), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_oe_async", 32'(sda_oe), 32'd0);
      check("t6_busy_rst", 32'(busy), 32'd0);
      m_scl = 1'b1;
      m_sda = 1'b1;
      repeat (5) @(negedge clk_sda);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_sda);
      check("t6_wr_before_rst", 32'(wr_count - wr0), 32'd1);
      wr0 = wr_count;
      exp_q.push_back({8'd4, 8'h80});
      i2c_start();
      send_byte(8'h14, ack);
      check("t6_dev2_ack", 32'(ack), 32'd1);
      send_byte(8'd4, ack);
      check("t6_reg2_ack", 32'(ack), 32'd1);
      send_byte(8'h80, ack);
      check("t6_data2_ack", 32'(ack), 32'd1);
      i2c_stop();
      repeat (10) @(negedge clk_sda);
      check("t6_wr_count", 32'(wr_count - wr0), 32'd1);
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t6_busy_end", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
